// File: rtl/fib_trace_fifo.sv
// Trace capture FIFO for the Fibonacci core: samples {a,b,i,n} whenever the core
// strobes, drains first-word-fall-through over valid/ready, and counts samples lost to overflow.
module fib_trace_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [WIDTH-1:0]         in_i,
  input  logic [WIDTH-1:0]         in_n,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_a,
  output logic [WIDTH-1:0]         out_b,
  output logic [WIDTH-1:0]         out_i,
  output logic [WIDTH-1:0]         out_n,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf,
  output logic [CNT_W-1:0]         ovf_cnt,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic [4*WIDTH-1:0]   r_mem [DEPTH];
  logic                 r_ovf;
  logic [CNT_W-1:0]     r_ovf_cnt;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && out_ready;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
  assign w_push  = in_valid && (!w_full || w_pop);
  assign w_drop  = in_valid && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_push)
        r_count <= r_count - 1'b1;
    end
  end

  // Storage is cleared on reset so the head fields read zero while empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= {in_a, in_b, in_i, in_n};
    end
  end

  // A drop in the same cycle as a clear wins, leaving a count of one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else if (w_drop) begin
      r_ovf     <= 1'b1;
      r_ovf_cnt <= clr_ovf ? CNT_W'(1) : sat_inc(r_ovf_cnt);
    end else if (clr_ovf) begin
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end
  end

  assign {out_a, out_b, out_i, out_n} = r_mem[r_rd_ptr];
  assign out_valid = !w_empty;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign ovf       = r_ovf;
  assign ovf_cnt   = r_ovf_cnt;

endmodule

// File: tb/tb_fib_trace_fifo.sv
// Self-checking bench for fib_trace_fifo: directed scenarios plus random traffic
// compared against a queue-based model of the capture FIFO.
module tb_fib_trace_fifo;

  localparam int W = 11;
  localparam int D = 8;
  localparam int C = 8;
  localparam int SAT = (1 << C) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic [W-1:0]   in_a = '0, in_b = '0, in_i = '0, in_n = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_a, out_b, out_i, out_n;
  logic [3:0]     count;
  logic           full, empty, ovf;
  logic [C-1:0]   ovf_cnt;
  logic           clr_ovf = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [4*W-1:0] q[$];
  bit             m_ovf;
  int             m_cnt;

  fib_trace_fifo #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_i(in_i), .in_n(in_n),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_i(out_i), .out_n(out_n),
    .count(count), .full(full), .empty(empty),
    .ovf(ovf), .ovf_cnt(ovf_cnt), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  // Advance one clock edge and apply the FIFO rules to the model using pre-edge inputs.
  task automatic step();
    bit             m_full, pop, push, drop;
    logic [4*W-1:0] e;
    m_full = (q.size() == D);
    pop    = (q.size() != 0) && out_ready;
    push   = in_valid && (!m_full || pop);
    drop   = in_valid && m_full && !pop;
    e      = {in_a, in_b, in_i, in_n};
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(e);
    if (drop) begin
      m_ovf = 1'b1;
      m_cnt = clr_ovf ? 1 : ((m_cnt < SAT) ? m_cnt + 1 : SAT);
    end else if (clr_ovf) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end
  endtask

  task automatic rand_data();
    in_a = W'($urandom); in_b = W'($urandom);
    in_i = W'($urandom); in_n = W'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({empty, count, out_valid, out_a, ovf_cnt} !== {1'b1, 4'd0, 1'b0, 11'd0, 8'd0}) begin
      failures++;
      $display("FAIL reset_state got empty=%0b count=%0d valid=%0b a=%0d ovf_cnt=%0d want 1/0/0/0/0",
               empty, count, out_valid, out_a, ovf_cnt);
    end
    rst = 1'b1;
    step();
    checks++;
    if (empty !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got empty=%0b valid=%0b want 1/0", empty, out_valid);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b0; in_valid = 1'b1;
    in_a = 11'd5; in_b = 11'd8; in_i = 11'd3; in_n = 11'd7;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_a, out_b, out_i, out_n, count} !== {1'b1, 11'd5, 11'd8, 11'd3, 11'd7, 4'd1}) begin
      failures++;
      $display("FAIL single_capture got v=%0b a=%0d b=%0d i=%0d n=%0d cnt=%0d want 1/5/8/3/7/1",
               out_valid, out_a, out_b, out_i, out_n, count);
    end
    step();
    checks++;
    if ({out_valid, out_a} !== {1'b1, 11'd5}) begin
      failures++;
      $display("FAIL single_hold got v=%0b a=%0d want 1/5", out_valid, out_a);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (empty !== 1'b1 || count !== 4'd0) begin
      failures++;
      $display("FAIL single_pop got empty=%0b count=%0d want 1/0", empty, count);
    end
  endtask

  task automatic test_fill_overflow();
    out_ready = 1'b0;
    for (int k = 0; k < 11; k++) begin
      in_valid = 1'b1;
      rand_data();
      in_a = W'(k);
      step();
    end
    in_valid = 1'b0;
    checks++;
    if ({full, count, ovf, ovf_cnt} !== {1'b1, 4'd8, 1'b1, 8'd3}) begin
      failures++;
      $display("FAIL fill_overflow got full=%0b count=%0d ovf=%0b ovf_cnt=%0d want 1/8/1/3",
               full, count, ovf, ovf_cnt);
    end
  endtask

  task automatic test_full_pop();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_a !== W'(k) || {out_a, out_b, out_i, out_n} !== q[0]) begin
        failures++;
        $display("FAIL full_pop_head[%0d] got a=%0d want a=%0d (model head %h)", k, out_a, k, q[0]);
      end
      in_valid = 1'b1; out_ready = 1'b1;
      rand_data();
      in_a = W'(100 + k);
      step();
      checks++;
      if ({count, full, ovf_cnt} !== {4'd8, 1'b1, 8'd3}) begin
        failures++;
        $display("FAIL full_pop_count[%0d] got count=%0d full=%0b ovf_cnt=%0d want 8/1/3",
                 k, count, full, ovf_cnt);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_clear_collision();
    clr_ovf = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    rand_data();
    step();
    checks++;
    if ({ovf, ovf_cnt} !== {1'b1, 8'd1}) begin
      failures++;
      $display("FAIL clear_vs_drop got ovf=%0b ovf_cnt=%0d want 1/1", ovf, ovf_cnt);
    end
    in_valid = 1'b0;
    step();
    clr_ovf = 1'b0;
    checks++;
    if ({ovf, ovf_cnt} !== {1'b0, 8'd0}) begin
      failures++;
      $display("FAIL clear_only got ovf=%0b ovf_cnt=%0d want 0/0", ovf, ovf_cnt);
    end
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (out_valid !== 1'b1 || {out_a, out_b, out_i, out_n} !== q[0]
          || (k < 4 && out_a !== W'(4 + k)) || (k >= 4 && out_a !== W'(96 + k))) begin
        failures++;
        $display("FAIL drain_head[%0d] got v=%0b a=%0d data=%h want model %h", k, out_valid, out_a,
                 {out_a, out_b, out_i, out_n}, q[0]);
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (empty !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty got empty=%0b valid=%0b want 1/0", empty, out_valid);
    end
  endtask

  task automatic test_random();
    logic [11:0] got, exp;
    int          bias;
    for (int k = 0; k < 400; k++) begin
      bias      = (k / 100) % 2;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = bias ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      rand_data();
      step();
      got = {out_valid, full, empty, count, ovf, 4'(ovf_cnt)};
      exp = {q.size() != 0, q.size() == D, q.size() == 0, 4'(q.size()), m_ovf, 4'(m_cnt)};
      checks++;
      if (got !== exp || ovf_cnt !== C'(m_cnt)) begin
        failures++;
        $display("FAIL random_status[%0d] got %h cnt=%0d want %h cnt=%0d", k, got, ovf_cnt, exp, m_cnt);
      end
      if (q.size() != 0) begin
        checks++;
        if ({out_a, out_b, out_i, out_n} !== q[0]) begin
          failures++;
          $display("FAIL random_head[%0d] got %h want %h", k, {out_a, out_b, out_i, out_n}, q[0]);
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic test_saturation_reset();
    clr_ovf = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
    rand_data();
    step();
    clr_ovf = 1'b0;
    for (int k = 0; k < 310; k++) begin
      rand_data();
      step();
    end
    checks++;
    if ({ovf, ovf_cnt, full} !== {1'b1, 8'd255, 1'b1} || m_cnt != SAT) begin
      failures++;
      $display("FAIL saturation got ovf=%0b ovf_cnt=%0d full=%0b want 1/255/1", ovf, ovf_cnt, full);
    end
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({out_valid, empty, full, count, ovf, ovf_cnt, out_a, out_b, out_i, out_n} !==
        {1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 44'd0}) begin
      failures++;
      $display("FAIL async_reset got v=%0b empty=%0b full=%0b count=%0d ovf=%0b ovf_cnt=%0d data=%h want all zero, empty=1",
               out_valid, empty, full, count, ovf, ovf_cnt, {out_a, out_b, out_i, out_n});
    end
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    in_valid = 1'b1;
    in_a = 11'd21; in_b = 11'd34; in_i = 11'd8; in_n = 11'd9;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, count, out_a, out_b, out_i, out_n} !== {1'b1, 4'd1, 11'd21, 11'd34, 11'd8, 11'd9}) begin
      failures++;
      $display("FAIL post_reset_push got v=%0b count=%0d a=%0d b=%0d i=%0d n=%0d want 1/1/21/34/8/9",
               out_valid, count, out_a, out_b, out_i, out_n);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_pop got empty=%0b want 1", empty);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_pop();
    test_clear_collision();
    test_drain();
    test_random();
    test_saturation_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fib_trace_fifo.md
# fib_trace_fifo

Downstream capture stage for the Fibonacci arithmetic core (`top`). Each cycle the core's `selector` is high, the block samples the core's 11-bit `a`, `b`, `i`, `n` outputs into a small first-word-fall-through FIFO. It drains them through a valid/ready port to a trace consumer, so property-mining benches can log core state without stalling the core. Dropped samples are counted and flagged because the core itself cannot be back-pressured.

## Interface
- `WIDTH`, default 11: width of each captured field.
- `DEPTH`, default 8: FIFO entries; power of two, minimum 2.
- `CNT_W`, default 8: width of the overflow drop counter.
- `AW`, derived as log2(`DEPTH`); not overridable.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-low.
- `in_valid`, in, 1: sample strobe; tied to the core's `selector`.
- `in_a`, `in_b`, `in_i`, `in_n`, in, `WIDTH` each: core outputs to capture.
- `out_valid`, out, 1: head entry available.
- `out_ready`, in, 1: consumer accepts the head entry.
- `out_a`, `out_b`, `out_i`, `out_n`, out, `WIDTH` each: head entry fields.
- `count`, out, `AW+1`: current occupancy, 0..`DEPTH`.
- `full`, out, 1: `count == DEPTH`.
- `empty`, out, 1: `count == 0`.
- `ovf`, out, 1: sticky flag; at least one sample was dropped.
- `ovf_cnt`, out, `CNT_W`: number of dropped samples; saturating.
- `clr_ovf`, in, 1: synchronous clear of `ovf` and `ovf_cnt`.

## Operation
- Storage: `DEPTH` x (4·`WIDTH`) register array, plus `AW`-bit write and read pointers and an `AW+1`-bit occupancy counter.
- Pop:
  - pop = `out_valid && out_ready`.
  - Pop advances the read pointer.
- Push:
  - push = `in_valid && (!full || pop)`.
  - Push writes {a,b,i,n} at the write pointer and advances it.
- Pointers wrap modulo `DEPTH` by natural `AW`-bit overflow; no explicit compare.
- Count update:
  - `count` += push − pop.
  - Simultaneous push and pop leaves `count` unchanged.
  - This holds when full: the write is accepted because pop frees a slot the same cycle.
- Drop:
  - drop = `in_valid && full && !pop`.
  - Sample is discarded and storage is untouched.
  - `ovf` is set; `ovf_cnt` increments, saturating at 2^`CNT_W`−1.
- Overflow clear:
  - `clr_ovf` clears `ovf` to 0 and `ovf_cnt` to 0.
  - If a drop occurs in the same cycle, the drop wins: `ovf`=1, `ovf_cnt`=1.
- Head output:
  - `out_*` = storage[read pointer], driven combinationally from registers.
  - `out_valid` = `!empty`.
  - `out_*` must be held stable while `out_valid && !out_ready`.
- `out_ready` while empty has no effect.
- `in_valid` with X/don't-care data is still captured verbatim; no checking of Fibonacci relations is done here.

## Timing
- On reset assertion, asynchronously and immediately:
  - pointers, `count` = 0; `empty`=1, `full`=0.
  - `out_valid`=0, `ovf`=0, `ovf_cnt`=0.
  - all storage = 0, so `out_a`/`out_b`/`out_i`/`out_n` = 0.
- Reset mid-operation discards all contents and the overflow history; the first edge after release behaves as from empty.
- Push-to-visible latency is 1 cycle: a sample pushed at edge k drives `out_*` with `out_valid`=1 after edge k. There is no same-cycle bypass when empty.
- Pop takes effect at the edge. The next head appears after that same edge, so back-to-back pops stream one entry per cycle.
- `full`, `empty`, `count` are registered-derived and change only at edges (or at reset).
- Throughput: sustained 1 push + 1 pop per cycle at any occupancy.

## Test plan
- Reset then idle: hold `rst`=0 for 2 cycles, release → `empty`=1, `count`=0, `out_valid`=0, `out_a`=0, `ovf_cnt`=0.
- Single capture: `in_valid`=1 one cycle with a=5, b=8, i=3, n=7, `out_ready`=0.
  - Next cycle: `out_valid`=1, `out_a`=5, `out_b`=8, `out_i`=3, `out_n`=7, `count`=1.
  - Raise `out_ready` one cycle → `empty`=1.
- Fill and overflow: `out_ready`=0, `in_valid`=1 for 11 cycles with a=0..10.
  - Result: `full`=1, `count`=8, `ovf`=1, `ovf_cnt`=3.
  - Draining yields a=0..7 in order.
- Full with simultaneous pop: at `count`=8, `in_valid`=1 and `out_ready`=1 for 4 cycles → no drops, `ovf_cnt` unchanged, `count` stays 8, FIFO order preserved across pointer wrap.
- Clear vs. drop collision: with `ovf_cnt`=3 while full, assert `clr_ovf` and `in_valid` with `out_ready`=0 → `ovf`=1, `ovf_cnt`=1. The following cycle, `clr_ovf` only → `ovf`=0, `ovf_cnt`=0.
- Saturation and reset mid-stream: force 300 drops with `CNT_W`=8 → `ovf_cnt`=255.
  - Assert `rst` low mid-stream → all outputs 0 and `empty`=1 immediately.
  - After release, a new push streams normally.
